// File: rtl/pps_stats_collector_if.sv
// pps_stats_collector_if: PPS/phase inputs and statistics outputs of the stats collector
//   master: drives pps_in, phase_valid, phase_error, clear_stats; reads the statistics
//   slave : the collector itself
interface pps_stats_collector_if;
   logic        pps_in;
   logic        phase_valid;
   logic [47:0] phase_error;
   logic        clear_stats;
   logic [31:0] pps_count;
   logic [31:0] error_count;
   logic [31:0] mtie;
   logic        mtie_valid;
   logic [31:0] max_abs_phase;
   logic        pps_missing;
   modport master (
      output pps_in, phase_valid, phase_error, clear_stats,
      input  pps_count, error_count, mtie, mtie_valid, max_abs_phase, pps_missing
   );
   modport slave (
      input  pps_in, phase_valid, phase_error, clear_stats,
      output pps_count, error_count, mtie, mtie_valid, max_abs_phase, pps_missing
   );
endinterface

// File: rtl/pps_stats_collector.sv
// pps_stats_collector: per-second PPS count, error count, windowed MTIE and peak |phase error|
//   clk, rst (async, active-high)
//   bus.pps_in, bus.phase_valid, bus.phase_error[47:0], bus.clear_stats  -> inputs
//   bus.pps_count, bus.error_count, bus.mtie, bus.mtie_valid, bus.max_abs_phase, bus.pps_missing -> outputs
module pps_stats_collector #(
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned WINDOW      = 16,
   parameter int unsigned ERR_THRESH  = 1000,
   parameter int unsigned PPS_TIMEOUT = CLK_FREQ * 11 / 10
) (
   input logic                  clk,
   input logic                  rst,
   pps_stats_collector_if.slave bus
);
   typedef enum logic {EMPTY, ACCUM} state_t;
   state_t             state;
   logic               pps_prev;
   logic [31:0]        tcnt;
   logic [15:0]        n;
   logic signed [31:0] wmin, wmax;
   logic               pps_edge, timeout, fits, samp_err, win_done;
   logic [31:0]        clamped, abs_s, mtie_n;
   logic signed [31:0] samp, nmin, nmax;
   logic [15:0]        n_next;
   logic [32:0]        err_sum, diff;
   always_comb begin
      pps_edge = bus.pps_in & ~pps_prev;
      timeout  = ~pps_edge && tcnt == PPS_TIMEOUT - 1;
      // 48b value fits in 32b signed only when bits 47..31 are all equal
      fits     = &bus.phase_error[47:31] | ~|bus.phase_error[47:31];
      clamped  = fits ? bus.phase_error[31:0] : (bus.phase_error[47] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      samp     = clamped;
      abs_s    = clamped[31] ? ~clamped + 32'd1 : clamped;
      samp_err = bus.phase_valid && abs_s >= ERR_THRESH;
      err_sum  = {1'b0, bus.error_count} + {32'd0, timeout} + {32'd0, samp_err};
      nmin     = (state == EMPTY || samp < wmin) ? samp : wmin;
      nmax     = (state == EMPTY || samp > wmax) ? samp : wmax;
      n_next   = state == EMPTY ? 16'd1 : n + 16'd1;
      win_done = bus.phase_valid && {16'd0, n_next} == WINDOW;
      diff     = {nmax[31], nmax} - {nmin[31], nmin};
      mtie_n   = diff[32] ? 32'hFFFF_FFFF : diff[31:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= EMPTY;
         pps_prev          <= 1'b0;
         tcnt              <= '0;
         n                 <= '0;
         wmin              <= '0;
         wmax              <= '0;
         bus.pps_count     <= '0;
         bus.error_count   <= '0;
         bus.mtie          <= '0;
         bus.mtie_valid    <= 1'b0;
         bus.max_abs_phase <= '0;
         bus.pps_missing   <= 1'b0;
      end else begin
         // tracked even during clear so a level already high is not counted afterwards
         pps_prev       <= bus.pps_in;
         bus.mtie_valid <= 1'b0;
         if (bus.clear_stats) begin
            state             <= EMPTY;
            tcnt              <= '0;
            n                 <= '0;
            wmin              <= '0;
            wmax              <= '0;
            bus.pps_count     <= '0;
            bus.error_count   <= '0;
            bus.mtie          <= '0;
            bus.max_abs_phase <= '0;
            bus.pps_missing   <= 1'b0;
         end else begin
            if (pps_edge) begin
               bus.pps_count   <= &bus.pps_count ? bus.pps_count : bus.pps_count + 32'd1;
               tcnt            <= '0;
               bus.pps_missing <= 1'b0;
            end else if (timeout) begin
               tcnt            <= '0;
               bus.pps_missing <= 1'b1;
            end else begin
               tcnt <= tcnt + 32'd1;
            end
            bus.error_count <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            if (bus.phase_valid) begin
               bus.max_abs_phase <= abs_s > bus.max_abs_phase ? abs_s : bus.max_abs_phase;
               wmin              <= nmin;
               wmax              <= nmax;
               if (win_done) begin
                  bus.mtie       <= mtie_n;
                  bus.mtie_valid <= 1'b1;
                  state          <= EMPTY;
                  n              <= '0;
               end else begin
                  state <= ACCUM;
                  n     <= n_next;
               end
            end
         end
      end
   end
endmodule
